// File: rtl/iob_gpio_poller.sv
`default_nettype none
// ============================================================================
// Module      : iob_gpio_poller
// Description : Autonomous IOb native-bus master for the GPIO peripheral.
//               Periodically reads the input register, reports per-bit
//               rising/falling edges, counts changed polls and mirrors every
//               changed sample to the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_gpio_poller #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int IN_ADDR  = 0,
   parameter int OUT_ADDR = 1,
   parameter int PERIOD   = 500000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic                  valid,
   output logic [ADDR_W-1:0]     address,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   input  logic [DATA_W-1:0]     rdata,
   input  logic                  ready,
   output logic [DATA_W-1:0]     sample,
   output logic [DATA_W-1:0]     rise,
   output logic [DATA_W-1:0]     fall,
   output logic [15:0]           event_cnt,
   output logic                  busy
);

   localparam int              CNT_W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PERIOD - 1);
   localparam logic [15:0]      EVT_MAX    = 16'hFFFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2
   } state_t;

   state_t                state_q,   state_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic                  primed_q,  primed_d;
   logic [DATA_W-1:0]     sample_q,  sample_d;
   logic [DATA_W-1:0]     rise_q,    rise_d;
   logic [DATA_W-1:0]     fall_q,    fall_d;
   logic [15:0]           evt_q,     evt_d;
   logic                  valid_q,   valid_d;
   logic [ADDR_W-1:0]     address_q, address_d;
   logic [DATA_W-1:0]     wdata_q,   wdata_d;
   logic [DATA_W/8-1:0]   wstrb_q,   wstrb_d;

   // Next-state logic; bus outputs are decoded from the next state so they
   // are registered together with the state and never glitch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      primed_d = primed_q;
      sample_d = sample_q;
      rise_d   = '0;
      fall_d   = '0;
      evt_d    = evt_q;

      case (state_q)
         S_IDLE: begin
            if (!en) begin
               cnt_d = CNT_RELOAD;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d   = CNT_RELOAD;
               state_d = S_RD;
            end
         end
         S_RD: begin
            if (ready) begin
               if (!primed_q) begin
                  // First poll only establishes the reference value.
                  sample_d = rdata;
                  primed_d = 1'b1;
                  state_d  = S_WR;
               end else if (rdata != sample_q) begin
                  rise_d   = rdata & ~sample_q;
                  fall_d   = ~rdata & sample_q;
                  sample_d = rdata;
                  if (evt_q != EVT_MAX) begin
                     evt_d = evt_q + 16'd1;
                  end
                  state_d  = S_WR;
               end else begin
                  state_d  = S_IDLE;
               end
            end
         end
         S_WR: begin
            if (ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      valid_d   = (state_d != S_IDLE);
      address_d = '0;
      wdata_d   = '0;
      wstrb_d   = '0;
      if (state_d == S_RD) begin
         address_d = ADDR_W'(IN_ADDR);
      end else if (state_d == S_WR) begin
         address_d = ADDR_W'(OUT_ADDR);
         wdata_d   = sample_d;
         wstrb_d   = '1;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= CNT_RELOAD;
         primed_q  <= 1'b0;
         sample_q  <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         evt_q     <= '0;
         valid_q   <= 1'b0;
         address_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         primed_q  <= primed_d;
         sample_q  <= sample_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         evt_q     <= evt_d;
         valid_q   <= valid_d;
         address_q <= address_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

   assign valid     = valid_q;
   assign address   = address_q;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign sample    = sample_q;
   assign rise      = rise_q;
   assign fall      = fall_q;
   assign event_cnt = evt_q;
   // The request flag is high exactly in RD or WR, so it doubles as busy.
   assign busy      = valid_q;

endmodule
`default_nettype wire

// File: doc/iob_gpio_poller.md
# iob_gpio_poller

Autonomous IOb native-bus master that drives the CPU-side interface of the GPIO peripheral. It periodically reads the peripheral's input register and detects per-bit rising and falling edges. It writes the sampled value back to the peripheral's output register whenever the sample changes. It sits beside or instead of the CPU on the peripheral's bus, so GPIO inputs can be mirrored to outputs and edge events counted without software.

## Interface

**Parameters**
- `DATA_W`, default 32: bus data width and GPIO sample width.
- `ADDR_W`, default 4: bus address width.
- `IN_ADDR`, default 0: address of the input register that is read on each poll.
- `OUT_ADDR`, default 1: address of the output register that is written on change.
- `PERIOD`, default 500000: number of idle cycles between polls. Must be ≥1.

**Ports** (clock and reset first)
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: enables polling.
- `valid` out 1: bus request.
- `address` out `ADDR_W`: bus address.
- `wdata` out `DATA_W`: write data.
- `wstrb` out `DATA_W/8`: write strobes. Zero means a read.
- `rdata` in `DATA_W`: read data. Valid in the cycle `ready`=1.
- `ready` in 1: slave completion.
- `sample` out `DATA_W`: last value read from `IN_ADDR`.
- `rise` out `DATA_W`: one-cycle mask of 0→1 bit transitions.
- `fall` out `DATA_W`: one-cycle mask of 1→0 bit transitions.
- `event_cnt` out 16: number of polls that saw a change. Saturates at 0xFFFF.
- `busy` out 1: high when the FSM is not IDLE.

## Operation
- FSM has three states: IDLE, RD, WR. It resets to IDLE.
- **Down-counter `cnt`** (width ⌈log2 PERIOD⌉, min 1):
  - Reset value is PERIOD-1.
  - Runs only in IDLE.
  - In IDLE with `en`=0: `cnt` reloads to PERIOD-1.
  - In IDLE with `en`=1 and `cnt`≠0: `cnt` decrements.
  - In IDLE with `en`=1 and `cnt`=0: FSM goes to RD and `cnt` reloads to PERIOD-1.
- **RD state:**
  - Drives `valid`=1, `address`=IN_ADDR, `wstrb`=0, `wdata`=0.
  - Waits for `ready`=1, then captures `rdata`.
- **On RD completion with value `d`:**
  - If the `primed` flag is 0 (first poll since reset): `sample`←`d`, `primed`←1, `rise`/`fall` stay 0, go to WR.
  - If `primed`=1 and `d`≠`sample`: `rise`←`d`&~`sample`, `fall`←~`d`&`sample`, `sample`←`d`, `event_cnt`+1 (saturating), go to WR.
  - If `primed`=1 and `d`=`sample`: go to IDLE with no pulses.
- **WR state:**
  - Drives `valid`=1, `address`=OUT_ADDR, `wdata`=`sample`, `wstrb`=all ones.
  - Waits for `ready`=1, then goes to IDLE.
- **Deasserting `en`** never aborts a transaction. The current RD/WR finishes and the FSM then stays in IDLE.
- **Reset outputs:** `valid`=0, `address`=0, `wdata`=0, `wstrb`=0, `sample`=0, `rise`=0, `fall`=0, `event_cnt`=0, `busy`=0, `primed`=0.

## Timing
- All outputs are registered. `rst` sampled high at edge N forces reset values from edge N onward, including in the middle of a transaction (`valid` drops).
- `en` sampled high at cycle 0 with `cnt`=PERIOD-1 makes `valid` (RD) high from cycle PERIOD.
- **Bus handshake:**
  - The master holds `valid`, `address`, `wdata` and `wstrb` stable until it samples `ready`=1.
  - `ready` may arrive in the first cycle of `valid`.
  - `valid` deasserts, or changes to the WR request, on the edge after `ready` is sampled.
  - `ready` while `valid`=0 is ignored.
- RD→WR: WR `valid` is high in the cycle right after the RD `ready` cycle. There is no idle gap, and `valid` stays high across both transactions.
- `sample`, `rise`, `fall` and `event_cnt` update on the edge after the RD `ready` cycle. `rise`/`fall` are high for exactly that one cycle.
- Back from IDLE, the next RD `valid` rises PERIOD cycles after IDLE entry (with `en`=1). PERIOD=1 gives exactly one IDLE cycle between transactions.
- `busy` is high exactly when the FSM is in RD or WR.

## Test plan
- **Reset and first poll.** PERIOD=4, `ready` tied high. Raise `en` at cycle 0 with `rdata`=0x5.
  - RD `valid` high at cycle 4 with `address`=IN_ADDR.
  - Cycle 5: WR with `address`=OUT_ADDR, `wdata`=0x5, `wstrb`=0xF.
  - `rise`/`fall` stay 0 throughout; `event_cnt`=0.
- **Edge detection.** After priming with 0x5, the next poll returns 0x6.
  - `rise`=0x2 and `fall`=0x1 for one cycle.
  - `sample`=0x6, `event_cnt`=1, WR `wdata`=0x6.
- **No change.** A poll returns the same value as `sample`.
  - No WR transaction; `rise`/`fall`=0; `event_cnt` unchanged.
  - Next RD `valid` rises 4 cycles after IDLE entry.
- **Wait states.** Slave delays `ready` by 3 cycles on both RD and WR.
  - `valid`/`address`/`wdata` stay stable the whole time.
  - Exactly one RD and one WR complete.
- **`en` deasserted mid-RD.** WR still completes, then `busy`=0 and no further `valid`. Reasserting `en` gives the next RD after 4 cycles.
- **Reset mid-WR and saturation.** Assert `rst` during WR `valid`: all outputs are 0 on the next cycle. Preload `event_cnt`=0xFFFF through many change-polls (or force it): it stays at 0xFFFF.
